// File: rtl/riscv_fetch_unit.sv
// ============================================================================
// riscv_fetch_unit : PC owner, imem request FSM and DEPTH-entry instruction FIFO
// Rev 1.0
// ============================================================================
`default_nettype none

module riscv_fetch_unit #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = {XLEN{1'b0}},
  parameter int unsigned     DEPTH        = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_base,
  input  logic [XLEN-1:0] redirect_offset,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst_data,
  output logic [XLEN-1:0] inst_pc,
  output logic            fetch_misaligned,
  output logic [XLEN-1:0] fetch_pc
);

  localparam int unsigned     PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned     CNT_W     = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_REQ      = 3'd1,
    ST_WAIT_RSP = 3'd2,
    ST_DROP     = 3'd3,
    ST_HALT     = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   req_pc_q, req_pc_d;
  logic              misaligned_q, misaligned_d;
  logic              halt_after_drop_q, halt_after_drop_d;

  logic [31:0]       fifo_data_q [DEPTH];
  logic [31:0]       fifo_data_d [DEPTH];
  logic [XLEN-1:0]   fifo_pc_q   [DEPTH];
  logic [XLEN-1:0]   fifo_pc_d   [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic [XLEN-1:0]   target;
  logic              req_fire;
  logic              push;
  logic              pop;
  logic              outstanding;
  logic              issue_ok;

  // Bit 0 of a jump target is architecturally ignored; bit 1 is a fault.
  assign target      = (redirect_base + redirect_offset) & ~XLEN'(1);
  assign req_fire    = (state_q == ST_REQ) && imem_req_ready;
  assign issue_ok    = (count_q < DEPTH_CNT);
  assign pop         = (count_q != '0) && inst_ready && !redirect_valid;
  assign push        = (state_q == ST_WAIT_RSP) && imem_rsp_valid && !redirect_valid &&
                       ((count_q != DEPTH_CNT) || pop);
  // A response landing in the same cycle as the redirect retires the old request.
  assign outstanding = req_fire ||
                       (((state_q == ST_WAIT_RSP) || (state_q == ST_DROP)) && !imem_rsp_valid);

  always_comb begin
    fifo_data_d = fifo_data_q;
    fifo_pc_d   = fifo_pc_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    if (redirect_valid) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        fifo_data_d[wr_ptr_q] = imem_rsp_data;
        fifo_pc_d[wr_ptr_q]   = req_pc_q;
        wr_ptr_d              = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_comb begin
    state_d           = state_q;
    pc_d              = pc_q;
    req_pc_d          = req_pc_q;
    misaligned_d      = misaligned_q;
    halt_after_drop_d = halt_after_drop_q;
    if (redirect_valid) begin
      pc_d              = target;
      misaligned_d      = target[1];
      halt_after_drop_d = target[1];
      if (outstanding) begin
        state_d = ST_DROP;
      end else if (target[1]) begin
        state_d = ST_HALT;
      end else begin
        state_d = ST_REQ;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (issue_ok) state_d = ST_REQ;
        end
        ST_REQ: begin
          if (imem_req_ready) begin
            pc_d     = pc_q + XLEN'(4);
            req_pc_d = pc_q;
            state_d  = ST_WAIT_RSP;
          end
        end
        ST_WAIT_RSP: begin
          if (imem_rsp_valid) state_d = (count_d < DEPTH_CNT) ? ST_REQ : ST_IDLE;
        end
        ST_DROP: begin
          if (imem_rsp_valid) state_d = halt_after_drop_q ? ST_HALT : ST_REQ;
        end
        ST_HALT: state_d = ST_HALT;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q           <= ST_IDLE;
      pc_q              <= RESET_VECTOR;
      req_pc_q          <= RESET_VECTOR;
      misaligned_q      <= 1'b0;
      halt_after_drop_q <= 1'b0;
      wr_ptr_q          <= '0;
      rd_ptr_q          <= '0;
      count_q           <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        fifo_data_q[i] <= '0;
        fifo_pc_q[i]   <= '0;
      end
    end else begin
      state_q           <= state_d;
      pc_q              <= pc_d;
      req_pc_q          <= req_pc_d;
      misaligned_q      <= misaligned_d;
      halt_after_drop_q <= halt_after_drop_d;
      wr_ptr_q          <= wr_ptr_d;
      rd_ptr_q          <= rd_ptr_d;
      count_q           <= count_d;
      fifo_data_q       <= fifo_data_d;
      fifo_pc_q         <= fifo_pc_d;
    end
  end

  assign imem_req_valid   = (state_q == ST_REQ);
  assign imem_req_addr    = pc_q & ~XLEN'(3);
  assign inst_valid       = (count_q != '0);
  assign inst_data        = fifo_data_q[rd_ptr_q];
  assign inst_pc          = fifo_pc_q[rd_ptr_q];
  assign fetch_misaligned = misaligned_q;
  assign fetch_pc         = pc_q;

endmodule

`default_nettype wire

// File: tb/tb_riscv_fetch_unit.sv
// ============================================================================
// tb_riscv_fetch_unit : directed + randomized bench with a transaction-level model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_riscv_fetch_unit;

  localparam int unsigned XLEN  = 32;
  localparam logic [31:0] RV    = 32'h0000_0000;
  localparam int unsigned DEPTH = 2;

  logic        clk;
  logic        reset_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_base;
  logic [31:0] redirect_offset;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        fetch_misaligned;
  logic [31:0] fetch_pc;

  riscv_fetch_unit #(.XLEN(XLEN), .RESET_VECTOR(RV), .DEPTH(DEPTH)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .imem_req_valid   (imem_req_valid),
    .imem_req_ready   (imem_req_ready),
    .imem_req_addr    (imem_req_addr),
    .imem_rsp_valid   (imem_rsp_valid),
    .imem_rsp_data    (imem_rsp_data),
    .redirect_valid   (redirect_valid),
    .redirect_base    (redirect_base),
    .redirect_offset  (redirect_offset),
    .inst_valid       (inst_valid),
    .inst_ready       (inst_ready),
    .inst_data        (inst_data),
    .inst_pc          (inst_pc),
    .fetch_misaligned (fetch_misaligned),
    .fetch_pc         (fetch_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } ent_t;

  // Reference model: instruction stream as a queue, plus next-fetch PC and memory state.
  ent_t        q[$];
  logic [31:0] exp_pc;
  bit          mis;
  bit          drop_pending;
  bit          mem_busy;
  logic [31:0] mem_addr;
  int unsigned mem_wait;
  bit          stall_prev;
  logic [31:0] last_hs_addr;
  bit          wrap_seen;

  int unsigned k_ready, k_inst, k_lat_lo, k_lat_hi, k_redir;
  bit          rd_req;
  logic [31:0] rd_base, rd_off;

  int n_cmp;
  int n_fail;
  int pops;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    exp_pc       = RV;
    mis          = 1'b0;
    drop_pending = 1'b0;
    mem_busy     = 1'b0;
    mem_wait     = 0;
    stall_prev   = 1'b0;
    last_hs_addr = 32'h1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_req_valid"}, imem_req_valid, 1'b0);
    check({tag, "_req_addr"},  imem_req_addr,  RV);
    check({tag, "_inst_valid"}, inst_valid,    1'b0);
    check({tag, "_inst_data"}, inst_data,      32'h0);
    check({tag, "_inst_pc"},   inst_pc,        32'h0);
    check({tag, "_misaligned"}, fetch_misaligned, 1'b0);
    check({tag, "_fetch_pc"},  fetch_pc,       RV);
  endtask

  task automatic cycle();
    logic [31:0] tgt;
    bit          hs, rsp, pop, redir;
    @(negedge clk);
    imem_req_ready = ($urandom_range(99) < k_ready);
    inst_ready     = ($urandom_range(99) < k_inst);
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = $urandom;
    if (mem_busy) begin
      if (mem_wait == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = word_of(mem_addr);
      end else begin
        mem_wait--;
      end
    end
    redir = rd_req || ($urandom_range(999) < k_redir);
    if (redir && !rd_req) begin
      rd_base = $urandom & 32'h0000_3FFC;
      rd_off  = (32'($urandom_range(63)) - 32'd32) << 2;
      if ($urandom_range(4) == 0) rd_off = rd_off | 32'h2;
      if ($urandom_range(2) == 0) rd_off = rd_off | 32'h1;
    end
    redirect_valid  = redir;
    redirect_base   = rd_base;
    redirect_offset = rd_off;
    rd_req          = 1'b0;
    #1;

    check("inst_valid", inst_valid, q.size() != 0);
    if (q.size() != 0) begin
      check("inst_pc",   inst_pc,   q[0].pc);
      check("inst_data", inst_data, q[0].data);
    end
    check("fetch_pc",   fetch_pc,         exp_pc);
    check("misaligned", fetch_misaligned, mis);
    if (mis) check("halt_no_req", imem_req_valid, 1'b0);
    if (stall_prev) check("req_hold", imem_req_valid, 1'b1);
    if (imem_req_valid) begin
      check("req_addr",         imem_req_addr,      exp_pc);
      check("single_outstand",  mem_busy,           1'b0);
      check("req_has_room",     q.size() < DEPTH,   1'b1);
    end

    hs  = imem_req_valid && imem_req_ready;
    rsp = imem_rsp_valid;
    pop = (q.size() != 0) && inst_ready;
    if (redir) begin
      tgt          = (redirect_base + redirect_offset) & ~32'h1;
      q.delete();
      drop_pending = (mem_busy && !rsp) || hs;
      exp_pc       = tgt;
      mis          = tgt[1];
    end else begin
      if (pop) begin
        void'(q.pop_front());
        pops++;
      end
      if (rsp) begin
        if (drop_pending) drop_pending = 1'b0;
        else q.push_back('{pc: mem_addr, data: word_of(mem_addr)});
      end
      if (hs) exp_pc = exp_pc + 32'd4;
    end
    if (rsp) mem_busy = 1'b0;
    if (hs) begin
      mem_busy = 1'b1;
      mem_addr = imem_req_addr;
      mem_wait = $urandom_range(k_lat_hi, k_lat_lo);
      if (last_hs_addr == 32'hFFFF_FFFC && imem_req_addr == 32'h0) wrap_seen = 1'b1;
      last_hs_addr = imem_req_addr;
    end
    stall_prev = imem_req_valid && !imem_req_ready && !redir;
  endtask

  initial begin
    int p0;
    int guard;
    n_cmp = 0; n_fail = 0; pops = 0; wrap_seen = 1'b0;
    reset_n = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    redirect_valid = 1'b0; redirect_base = '0; redirect_offset = '0; inst_ready = 1'b0;
    k_ready = 100; k_inst = 100; k_lat_lo = 0; k_lat_hi = 0; k_redir = 0;
    rd_req = 1'b0; rd_base = '0; rd_off = '0;
    model_reset();

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals("rst");
    reset_n = 1'b1;
    #1 check("first_req_idle", imem_req_valid, 1'b0);
    @(negedge clk);
    #1 check("first_req", imem_req_valid, 1'b1);
    check("first_addr", imem_req_addr, RV);

    // Sequential fetch with single-cycle memory
    p0 = pops;
    repeat (40) cycle();
    check("seq_throughput", (pops - p0) >= 18, 1'b1);

    // Decode back-pressure fills the FIFO and stops fetch
    k_inst = 0;
    repeat (12) cycle();
    check("bp_no_req", imem_req_valid, 1'b0);
    check("bp_full_valid", inst_valid, 1'b1);
    k_inst = 100;
    repeat (12) cycle();

    // Redirect while a response is pending
    k_lat_lo = 2; k_lat_hi = 2;
    guard = 0;
    while (!(mem_busy && mem_wait == 2) && guard < 50) begin
      cycle();
      guard++;
    end
    check("wait_busy_bound", mem_busy && mem_wait == 2, 1'b1);
    rd_req = 1'b1; rd_base = 32'h100; rd_off = 32'hFFFF_FFF8;
    cycle();
    @(posedge clk);
    #1;
    check("redir_fetch_pc", fetch_pc, 32'h0000_00F8);
    check("redir_flush", inst_valid, 1'b0);
    k_lat_lo = 0; k_lat_hi = 0;
    repeat (12) cycle();

    // Misaligned JALR target halts fetch until an aligned redirect
    rd_req = 1'b1; rd_base = 32'h200; rd_off = 32'h3;
    cycle();
    repeat (8) cycle();
    check("mis_flag", fetch_misaligned, 1'b1);
    check("mis_halt", imem_req_valid, 1'b0);
    check("mis_pc", fetch_pc, 32'h202);
    rd_req = 1'b1; rd_base = 32'h300; rd_off = 32'h0;
    cycle();
    @(posedge clk);
    #1;
    check("realign_flag", fetch_misaligned, 1'b0);
    check("realign_pc", fetch_pc, 32'h300);
    repeat (10) cycle();

    // Memory stall, then redirect during the stall
    k_ready = 0;
    repeat (8) cycle();
    check("stall_valid", imem_req_valid, 1'b1);
    rd_req = 1'b1; rd_base = 32'h400; rd_off = 32'h10;
    cycle();
    @(posedge clk);
    #1;
    check("stall_redir_addr", imem_req_addr, 32'h410);
    check("stall_redir_valid", imem_req_valid, 1'b1);
    k_ready = 100;
    repeat (6) cycle();

    // PC wrap at the top of the address space
    wrap_seen = 1'b0;
    rd_req = 1'b1; rd_base = 32'hFFFF_FFF0; rd_off = 32'h8;
    cycle();
    repeat (12) cycle();
    check("pc_wrap", wrap_seen, 1'b1);

    // Asynchronous reset while a response is outstanding
    k_lat_lo = 2; k_lat_hi = 2;
    guard = 0;
    while (!(mem_busy && mem_wait == 2) && guard < 50) begin
      cycle();
      guard++;
    end
    check("rst_busy_bound", mem_busy && mem_wait == 2, 1'b1);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    imem_rsp_valid = 1'b1; imem_rsp_data = word_of(mem_addr);
    redirect_valid = 1'b0; imem_req_ready = 1'b0; inst_ready = 1'b0;
    #1 check_reset_vals("rst_mid");
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    #1 check("rst_idle", imem_req_valid, 1'b0);
    @(negedge clk);
    #1;
    check("late_rsp_ignored", inst_valid, 1'b0);
    check("rst_first_req", imem_req_valid, 1'b1);
    check("rst_fetch_pc", fetch_pc, RV);
    imem_rsp_valid = 1'b0;
    k_lat_lo = 0; k_lat_hi = 0;

    // Randomized traffic
    p0 = pops;
    k_redir = 30;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) begin
        k_ready  = $urandom_range(100, 30);
        k_inst   = $urandom_range(100, 20);
        k_lat_lo = 0;
        k_lat_hi = $urandom_range(3);
      end
      cycle();
    end
    check("random_progress", (pops - p0) > 100, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/riscv_fetch_unit.md
# riscv_fetch_unit

Parametrised instruction-fetch front end for the multicycle RISC-V core, replacing the inline PC register and FETCH state of the core top level. It owns the program counter and issues word requests to instruction memory over a valid/ready handshake. Returned instructions are buffered in a DEPTH-entry FIFO toward decode. The block also accepts branch/jump redirects computed as base + offset, flushes stale work on a redirect and flags misaligned targets.

## Interface
- XLEN, 32, address/data width (32 only for RV32; kept generic for buses)
- RESET_VECTOR, 32'h0000_0000, PC value loaded at reset
- DEPTH, 2, instruction FIFO entries; power of two, ≥2
- clk  in  1  core clock
- reset_n  in  1  asynchronous, active-low reset
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  XLEN  word address of request (bits [1:0] = 0)
- imem_rsp_valid  in  1  response data valid (one pulse per accepted request)
- imem_rsp_data  in  32  instruction word
- redirect_valid  in  1  one-cycle branch/jump redirect
- redirect_base  in  XLEN  PC of branch (JAL/branch) or rs1 (JALR)
- redirect_offset  in  XLEN  sign-extended immediate
- inst_valid  out  1  FIFO head valid toward decode
- inst_ready  in  1  decode consumes head
- inst_data  out  32  head instruction
- inst_pc  out  XLEN  PC of head instruction
- fetch_misaligned  out  1  sticky: last redirect target had bit 1 set
- fetch_pc  out  XLEN  current next-fetch PC (debug)

## Operation
- States: IDLE, REQ, WAIT_RSP, DROP, HALT.
- IDLE: entered at reset; next cycle → REQ if issue allowed, else stay.
- Issue allowed: fifo_count < DEPTH and not HALT.
- REQ: imem_req_valid = 1, imem_req_addr = pc. On valid&&ready: pc ← pc + 4 (XLEN wrap, 32'hFFFF_FFFC + 4 = 0), → WAIT_RSP.
- WAIT_RSP: on imem_rsp_valid, write {data, request PC} into FIFO; → REQ if still allowed (count after write), else IDLE.
- Redirect target = (redirect_base + redirect_offset) & ~1, XLEN-bit wrap.
- Redirect, any state: FIFO flushed (count ← 0, inst_valid low next cycle), and pc ← target.
  - If a request is outstanding (WAIT_RSP, or REQ handshake completing this cycle) → DROP; else → REQ.
  - If target[1] = 1: fetch_misaligned ← 1, pc ← target, → HALT (or DROP first if outstanding, then HALT).
- DROP: next imem_rsp_valid discarded, not written; then → REQ or HALT.
- HALT: no requests; leaves only on a redirect with aligned target (clears fetch_misaligned).
- Redirect has priority over a simultaneous response write, pop or handshake bookkeeping.
- FIFO: simultaneous push and pop allowed when full (pop frees slot first); no push when full. Issue check guarantees an accepted response always has a slot.
- At most one outstanding request.

## Timing
- Reset values: imem_req_valid 0, imem_req_addr RESET_VECTOR, inst_valid 0, inst_data 0, inst_pc 0, fetch_misaligned 0, fetch_pc RESET_VECTOR, state IDLE, FIFO empty.
- First request: imem_req_valid high in the 2nd rising edge after reset_n deasserts (IDLE one cycle).
- imem_req_valid/addr held stable until ready; never dropped without a redirect.
- Response in cycle N → inst_valid high from cycle N+1 (registered FIFO); next request valid in N+1.
- Best-case throughput with 1-cycle memory: one instruction per 2 cycles.
- Redirect in cycle N → request at target valid in N+1 (no outstanding) or cycle after dropped response.
- inst_pc/inst_data stable while inst_valid && !inst_ready.
- Reset mid-operation: all state cleared immediately; responses arriving during/after reset before a new request are ignored (state IDLE).

## Test plan
- Reset, imem always ready, 1-cycle response, inst_ready=1 → addresses 0,4,8,…; inst_pc matches; inst_data matches returned words in order.
- inst_ready=0, DEPTH=2 → exactly 2 entries fetched, imem_req_valid stays 0; raise inst_ready → fetch resumes at 8 with no loss/duplication.
- Redirect base=0x100, offset=-8 while WAIT_RSP → pending response discarded, FIFO empty, next request addr 0xF8.
- Redirect base=0x200, offset=0x3 (JALR) → target 0x202, fetch_misaligned=1, no requests; redirect to 0x300 clears flag, fetch from 0x300.
- imem_req_ready low 5 cycles → addr stable throughout, pc advances only on handshake; redirect during stall replaces addr next cycle.
- PC 32'hFFFF_FFFC → next request 0x0; reset_n asserted mid-WAIT_RSP → all outputs return to reset values, late response ignored.
